// File: rtl/mdu_pkg.sv
// Shared encodings for the E-stage multiply/divide unit.
// Op codes, FSM states and default latencies.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIV  = 2'd2
  } mdu_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu_core.sv
// Combinational signed/unsigned multiply and divide.
// Division by zero yields zeros and raises o_dz.
module mdu_core
  import mdu_pkg::*;
(
  input  mdu_op_e     i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_dz
);

  logic        w_sgn;
  logic        w_mul;
  logic        w_div;
  logic [63:0] w_ax;
  logic [63:0] w_bx;
  logic [63:0] w_prod;
  logic [31:0] w_an;
  logic [31:0] w_bn;
  logic [31:0] w_den;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic [31:0] w_qn;
  logic [31:0] w_rn;
  logic        w_dz;

  assign w_sgn = (i_op == OP_MULT) || (i_op == OP_DIV);
  assign w_mul = (i_op == OP_MULT) || (i_op == OP_MULTU);
  assign w_div = (i_op == OP_DIV) || (i_op == OP_DIVU);

  // low 64 bits of a sign-extended product equal the signed product
  assign w_ax   = {{32{w_sgn & i_a[31]}}, i_a};
  assign w_bx   = {{32{w_sgn & i_b[31]}}, i_b};
  assign w_prod = w_ax * w_bx;

  assign w_an  = (w_sgn & i_a[31]) ? -i_a : i_a;
  assign w_bn  = (w_sgn & i_b[31]) ? -i_b : i_b;
  assign w_dz  = (i_b == 32'd0);
  assign w_den = w_dz ? 32'd1 : w_bn;
  assign w_q   = w_an / w_den;
  assign w_r   = w_an % w_den;
  assign w_qn  = (w_sgn & (i_a[31] ^ i_b[31])) ? -w_q : w_q;
  assign w_rn  = (w_sgn & i_a[31]) ? -w_r : w_r;

  always_comb begin
    o_hi = 32'd0;
    o_lo = 32'd0;
    o_dz = 1'b0;
    unique case (1'b1)
      w_mul: begin
        o_hi = w_prod[63:32];
        o_lo = w_prod[31:0];
      end
      w_div: begin
        o_hi = w_dz ? 32'd0 : w_rn;
        o_lo = w_dz ? 32'd0 : w_qn;
        o_dz = w_dz;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// E-stage mult/div unit owning HI/LO; fixed-latency commit.
// Optional E_MDU_Cancel port when MDU_CANCEL_EN is defined.
module e_mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_MDU_Start,
  input  logic [3:0]  E_MDU_Op,
  input  logic [31:0] E_RS,
  input  logic [31:0] E_RT,
`ifdef MDU_CANCEL_EN
  input  logic        E_MDU_Cancel,
`endif
  output logic        E_MDU_Busy,
  output logic [31:0] E_HI,
  output logic [31:0] E_LO,
  output logic [31:0] E_MDU_Result
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                        MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  mdu_op_e     w_op;
  logic [31:0] w_hi;
  logic [31:0] w_lo;
  logic        w_dz;
  logic        w_busy;
  logic        w_go;
  logic        w_cancel;
  logic        w_is_mul;
  logic        w_is_div;
  logic        w_commit;

  mdu_state_e  r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_hi_nxt;
  logic [31:0] r_lo_nxt;
  logic        r_dz;

  assign w_op = mdu_op_e'(E_MDU_Op);

  mdu_core u_core (
    .i_op (w_op),
    .i_a  (E_RS),
    .i_b  (E_RT),
    .o_hi (w_hi),
    .o_lo (w_lo),
    .o_dz (w_dz)
  );

  assign w_busy = (r_cnt != '0);

`ifdef MDU_CANCEL_EN
  assign w_cancel = E_MDU_Cancel & w_busy;
  assign w_go     = E_MDU_Start & ~w_busy & ~E_MDU_Cancel;
`else
  assign w_cancel = 1'b0;
  assign w_go     = E_MDU_Start & ~w_busy;
`endif

  assign w_is_mul = (w_op == OP_MULT) || (w_op == OP_MULTU);
  assign w_is_div = (w_op == OP_DIV) || (w_op == OP_DIVU);
  // a divide by zero runs its full latency but never writes HI/LO
  assign w_commit = (r_state == S_MULT) || !r_dz;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_hi_nxt <= 32'd0;
      r_lo_nxt <= 32'd0;
      r_dz     <= 1'b0;
    end else if (w_cancel) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else if (w_busy) begin
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) begin
        r_state <= S_IDLE;
        if (w_commit) begin
          r_hi <= r_hi_nxt;
          r_lo <= r_lo_nxt;
        end
      end
    end else if (w_go) begin
      unique case (1'b1)
        w_is_mul: begin
          r_state  <= S_MULT;
          r_cnt    <= CW'(MULT_CYCLES);
          r_hi_nxt <= w_hi;
          r_lo_nxt <= w_lo;
          r_dz     <= 1'b0;
        end
        w_is_div: begin
          r_state  <= S_DIV;
          r_cnt    <= CW'(DIV_CYCLES);
          r_hi_nxt <= w_hi;
          r_lo_nxt <= w_lo;
          r_dz     <= w_dz;
        end
        (w_op == OP_MTHI): r_hi <= E_RS;
        (w_op == OP_MTLO): r_lo <= E_RS;
        default: ;
      endcase
    end
  end

  assign E_MDU_Busy = w_busy;
  assign E_HI       = r_hi;
  assign E_LO       = r_lo;

  always_comb begin
    E_MDU_Result = 32'd0;
    if (w_op == OP_MFHI) E_MDU_Result = r_hi;
    else if (w_op == OP_MFLO) E_MDU_Result = r_lo;
  end

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu with an expected-result queue.
// Define MDU_CANCEL_EN to also exercise the cancel port.
module tb_e_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        E_MDU_Start = 1'b0;
  logic [3:0]  E_MDU_Op = 4'd0;
  logic [31:0] E_RS = 32'd0;
  logic [31:0] E_RT = 32'd0;
  logic        E_MDU_Cancel = 1'b0;
  logic        E_MDU_Busy;
  logic [31:0] E_HI;
  logic [31:0] E_LO;
  logic [31:0] E_MDU_Result;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [63:0] sb[$];

  e_mdu dut (
    .clk          (clk),
    .reset        (reset),
    .E_MDU_Start  (E_MDU_Start),
    .E_MDU_Op     (E_MDU_Op),
    .E_RS         (E_RS),
    .E_RT         (E_RT),
`ifdef MDU_CANCEL_EN
    .E_MDU_Cancel (E_MDU_Cancel),
`endif
    .E_MDU_Busy   (E_MDU_Busy),
    .E_HI         (E_HI),
    .E_LO         (E_LO),
    .E_MDU_Result (E_MDU_Result)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [3:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [31:0] hi,
                                        input logic [31:0] lo);
    logic signed [63:0] sa;
    logic signed [63:0] sb2;
    logic signed [63:0] q;
    logic signed [63:0] r;
    sa  = {{32{a[31]}}, a};
    sb2 = {{32{b[31]}}, b};
    model = {hi, lo};
    case (op)
      OP_MULT:  model = sa * sb2;
      OP_MULTU: model = {32'd0, a} * {32'd0, b};
      OP_DIV: if (b != 0) begin
        q = sa / sb2;
        r = sa % sb2;
        model = {r[31:0], q[31:0]};
      end
      OP_DIVU: if (b != 0) model = {a % b, a / b};
      default: ;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    E_MDU_Start = 1'b1;
    E_MDU_Op = op;
    E_RS = a;
    E_RT = b;
    #1 chk("busy_issue", {31'd0, E_MDU_Busy}, 32'd0);
    @(negedge clk);
    E_MDU_Start = 1'b0;
    E_MDU_Op = OP_NONE;
  endtask

  task automatic run_md(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int n);
    int cnt;
    logic [63:0] e;
    sb.push_back(model(op, a, b, m_hi, m_lo));
    issue(op, a, b);
    cnt = 0;
    while (E_MDU_Busy && cnt < 60) begin
      cnt++;
      @(negedge clk);
    end
    chk({tag, "_busy"}, cnt, n);
    e = sb.pop_front();
    chk({tag, "_hi"}, E_HI, e[63:32]);
    chk({tag, "_lo"}, E_LO, e[31:0]);
    m_hi = e[63:32];
    m_lo = e[31:0];
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] v);
    @(negedge clk);
    E_MDU_Start = 1'b1;
    E_MDU_Op = op;
    E_RS = v;
    @(negedge clk);
    E_MDU_Start = 1'b0;
    E_MDU_Op = OP_NONE;
    if (op == OP_MTHI) m_hi = v;
    else m_lo = v;
  endtask

  initial begin
    int cnt;
    logic [63:0] e;
    logic [31:0] ra;
    logic [31:0] rb;

    repeat (2) @(negedge clk);
    E_MDU_Op = OP_MFHI;
    #1;
    chk("rst_busy", {31'd0, E_MDU_Busy}, 32'd0);
    chk("rst_hi", E_HI, 32'd0);
    chk("rst_lo", E_LO, 32'd0);
    chk("rst_res", E_MDU_Result, 32'd0);
    E_MDU_Op = OP_NONE;
    reset = 1'b1;

    run_md("mult", OP_MULT, 32'hFFFFFFFF, 32'h2, 5);
    chk("mult_hi_lit", E_HI, 32'hFFFFFFFF);
    chk("mult_lo_lit", E_LO, 32'hFFFFFFFE);
    run_md("multu", OP_MULTU, 32'hFFFFFFFF, 32'h2, 5);
    chk("multu_hi_lit", E_HI, 32'h00000001);
    run_md("div", OP_DIV, 32'hFFFFFFF9, 32'h2, 10);
    chk("div_lo_lit", E_LO, 32'hFFFFFFFD);
    chk("div_hi_lit", E_HI, 32'hFFFFFFFF);

    mt(OP_MTHI, 32'h1234);
    chk("mthi", E_HI, 32'h1234);
    mt(OP_MTLO, 32'h1234);
    chk("mtlo", E_LO, 32'h1234);
    run_md("divu0", OP_DIVU, 32'd7, 32'd0, 10);
    run_md("div0", OP_DIV, 32'd7, 32'd0, 10);
    run_md("ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 10);
    chk("ovf_lo_lit", E_LO, 32'h80000000);
    run_md("divn", OP_DIV, 32'd17, 32'hFFFFFFFB, 10);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      run_md("rmult", OP_MULT, ra, rb, 5);
      run_md("rmultu", OP_MULTU, ra, rb, 5);
      run_md("rdiv", OP_DIV, ra, rb >> i, 10);
      run_md("rdivu", OP_DIVU, ra, rb >> (i * 8), 10);
    end

    mt(OP_MTLO, 32'hDEADBEEF);
    E_MDU_Op = OP_MFLO;
    #1 chk("mflo", E_MDU_Result, 32'hDEADBEEF);
    E_MDU_Op = OP_MFHI;
    #1 chk("mfhi", E_MDU_Result, m_hi);
    E_MDU_Op = OP_MTHI;
    #1 chk("res_other", E_MDU_Result, 32'd0);
    E_MDU_Op = OP_NONE;

    sb.push_back(model(OP_MULT, 32'd3, 32'd5, m_hi, m_lo));
    issue(OP_MULT, 32'd3, 32'd5);
    E_MDU_Start = 1'b1;
    E_MDU_Op = OP_MULT;
    E_RS = 32'd7;
    E_RT = 32'd9;
    @(negedge clk);
    E_MDU_Op = OP_MTHI;
    E_RS = 32'hAAAA;
    @(negedge clk);
    E_MDU_Start = 1'b0;
    E_MDU_Op = OP_NONE;
    cnt = 2;
    while (E_MDU_Busy && cnt < 60) begin
      cnt++;
      @(negedge clk);
    end
    chk("ign_busy", cnt, 5);
    e = sb.pop_front();
    chk("ign_hi", E_HI, e[63:32]);
    chk("ign_lo", E_LO, e[31:0]);
    m_hi = e[63:32];
    m_lo = e[31:0];
    repeat (8) @(negedge clk);
    chk("ign_late", E_LO, 32'd15);

    @(negedge clk);
    E_MDU_Start = 1'b1;
    E_MDU_Op = 4'hF;
    E_RS = 32'h5555;
    E_RT = 32'h3;
    @(negedge clk);
    E_MDU_Start = 1'b0;
    E_MDU_Op = OP_NONE;
    #1;
    chk("ill_busy", {31'd0, E_MDU_Busy}, 32'd0);
    chk("ill_hi", E_HI, m_hi);
    chk("ill_lo", E_LO, m_lo);

`ifdef MDU_CANCEL_EN
    mt(OP_MTHI, 32'h11);
    mt(OP_MTLO, 32'h22);
    issue(OP_MULT, 32'd100, 32'd100);
    repeat (4) @(negedge clk);
    E_MDU_Cancel = 1'b1;
    @(negedge clk);
    E_MDU_Cancel = 1'b0;
    chk("can_busy", {31'd0, E_MDU_Busy}, 32'd0);
    repeat (8) @(negedge clk);
    chk("can_hi", E_HI, 32'h11);
    chk("can_lo", E_LO, 32'h22);
    @(negedge clk);
    E_MDU_Cancel = 1'b1;
    E_MDU_Start = 1'b1;
    E_MDU_Op = OP_MTHI;
    E_RS = 32'h99;
    @(negedge clk);
    E_MDU_Cancel = 1'b0;
    E_MDU_Start = 1'b0;
    E_MDU_Op = OP_NONE;
    chk("can_start", E_HI, 32'h11);
`endif

    issue(OP_DIV, 32'd100, 32'd7);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rmid_busy", {31'd0, E_MDU_Busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    chk("rmid_hi", E_HI, 32'd0);
    chk("rmid_lo", E_LO, 32'd0);
    repeat (15) @(negedge clk);
    chk("rmid_late_busy", {31'd0, E_MDU_Busy}, 32'd0);
    chk("rmid_late_hi", E_HI, 32'd0);
    chk("rmid_late_lo", E_LO, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
